// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory access stage.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int unsigned DMEM_WORD_W     = 32;
    localparam int unsigned DMEM_WAIT_CNT_W = 3;

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data array: synchronous write, asynchronous read, no reset.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64
) (
    input  logic                           CLK,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [DMEM_WORD_W-1:0]         din,
    output logic [DMEM_WORD_W-1:0]         dout
);

    logic [DMEM_WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[idx] <= din;
        end
    end

    assign dout = mem[idx];

endmodule

// File: rtl/dmem_access.sv
// Data-memory access stage: request latch, wait-state FSM and one-cycle response pulse.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses and suppress their stores.
module dmem_access
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [DMEM_WORD_W-1:0] addr,
    input  logic [DMEM_WORD_W-1:0] wdata,
    output logic                   rsp_valid,
    output logic [DMEM_WORD_W-1:0] rdata,
    output logic                   rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    dmem_state_t                state;
    logic [DMEM_WAIT_CNT_W-1:0] cnt;
    logic                       rd_q, wr_q;
    logic [IDX_W+1:0]           addr_q;
    logic [DMEM_WORD_W-1:0]     wdata_q;

    logic                   cur_rd, cur_wr, cur_err, go_resp, ram_we;
    logic [IDX_W+1:0]       cur_addr;
    logic [DMEM_WORD_W-1:0] cur_wdata, ram_dout, rdata_d;
    logic                   unused_bits;

    // With zero wait states the request commits on its acceptance edge, so
    // the live inputs stand in for the not-yet-written latch.
    always_comb begin
        cur_rd    = rd_q;
        cur_wr    = wr_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state == IDLE) begin
            cur_rd    = mem_read;
            cur_wr    = mem_write;
            cur_addr  = addr[IDX_W+1:0];
            cur_wdata = wdata;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign cur_err = (cur_rd | cur_wr) & (cur_addr[1:0] != 2'b00);
`else
    assign cur_err = 1'b0;
`endif

    assign go_resp = ((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && (cnt <= DMEM_WAIT_CNT_W'(1)));
    assign ram_we  = go_resp && !Reset && cur_wr && !cur_err;

    always_comb begin
        rdata_d = '0;
        if (!cur_err && cur_wr) begin
            rdata_d = cur_wdata;
        end else if (!cur_err && cur_rd) begin
            rdata_d = ram_dout;
        end
    end

    assign req_ready   = (state == IDLE);
    assign unused_bits = ^{addr[DMEM_WORD_W-1:IDX_W+2], cur_addr[1:0]};

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .CLK (CLK),
        .we  (ram_we),
        .idx (cur_addr[IDX_W+1:2]),
        .din (cur_wdata),
        .dout(ram_dout)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rdata     <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rdata     <= '0;
            rsp_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        rd_q    <= mem_read;
                        wr_q    <= mem_write;
                        addr_q  <= addr[IDX_W+1:0];
                        wdata_q <= wdata;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= DMEM_WAIT_CNT_W'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - DMEM_WAIT_CNT_W'(1);
                    if (cnt <= DMEM_WAIT_CNT_W'(1)) begin
                        state <= RESP;
                        cnt   <= '0;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (go_resp) begin
                rsp_valid <= 1'b1;
                rdata     <= rdata_d;
                rsp_err   <= cur_err;
            end
        end
    end

endmodule
